// File: rtl/ram_record_reader.sv
// ram_record_reader
// -----------------
// Sequential reader for the synchronous-read port of a dual-port block RAM.
// A start command latches a base address and a record count. The reader then
// walks the address range, gathers REC_BYTES consecutive words into one record
// and offers each record on a valid/ready stream. The next record's reads are
// issued only after the current record has been handed over.
//
// Ports
//   clock        system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   start        command strobe, honoured only while idle
//   base_addr    first RAM address of the command
//   rec_count    number of records in the command (0 completes at once)
//   abort        cancels the current command, no done pulse
//   ram_enable   RAM read enable
//   ram_address  RAM read address
//   ram_q        RAM read data, valid one edge after the enable
//   rec_data     assembled record, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rec_valid    record available
//   rec_ready    consumer accepts the record
//   busy         high whenever a command is in progress
//   done         one-cycle pulse on normal completion
module ram_record_reader #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 8,
   parameter int REC_BYTES  = 4,
   parameter int CNT_WIDTH  = 7
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            start,
   input  logic [ADDR_WIDTH-1:0]           base_addr,
   input  logic [CNT_WIDTH-1:0]            rec_count,
   input  logic                            abort,
   output logic                            ram_enable,
   output logic [ADDR_WIDTH-1:0]           ram_address,
   input  logic [DATA_WIDTH-1:0]           ram_q,
   output logic [REC_BYTES*DATA_WIDTH-1:0] rec_data,
   output logic                            rec_valid,
   input  logic                            rec_ready,
   output logic                            busy,
   output logic                            done
);

   localparam int SLOT_WIDTH = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;
   localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = SLOT_WIDTH'(REC_BYTES - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DRAIN  = 3'd2;
   localparam logic [2:0] ST_HOLD   = 3'd3;
   localparam logic [2:0] ST_FINISH = 3'd4;

   logic [2:0]                      state_q, state_d;
   logic [ADDR_WIDTH-1:0]           ptr_q, ptr_d;
   logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;
   logic [SLOT_WIDTH-1:0]           rdSlot_q, rdSlot_d;
   logic                            capEn_q, capEn_d;
   logic [SLOT_WIDTH-1:0]           capSlot_q, capSlot_d;
   logic                            ramEn_q, ramEn_d;
   logic [ADDR_WIDTH-1:0]           ramAddr_q, ramAddr_d;
   logic [REC_BYTES*DATA_WIDTH-1:0] recData_q, recData_d;
   logic                            recValid_q, recValid_d;
   logic                            busy_q, busy_d;
   logic                            done_q, done_d;

   // Next-state logic. ptr_q always holds the next address to issue, and
   // rdSlot_q is the record slot of the read currently on the bus. The read
   // on the bus is sampled by the RAM at the coming edge, so its data shows
   // up on ram_q one cycle later; capEn_q/capSlot_q delay the slot tag by
   // that one edge so the capture lands two edges after the address.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      rdSlot_d   = rdSlot_q;
      capEn_d    = ramEn_q;
      capSlot_d  = rdSlot_q;
      ramEn_d    = 1'b0;
      ramAddr_d  = ramAddr_q;
      recData_d  = recData_q;
      recValid_d = recValid_q;
      done_d     = 1'b0;

      if (capEn_q) begin
         for (int k = 0; k < REC_BYTES; k++) begin
            if (capSlot_q == SLOT_WIDTH'(k)) begin
               recData_d[k*DATA_WIDTH +: DATA_WIDTH] = ram_q;
            end
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_d     = rec_count;
               ramAddr_d = base_addr;
               ptr_d     = base_addr + ADDR_WIDTH'(1);
               rdSlot_d  = '0;
               if (rec_count == '0) begin
                  state_d = ST_FINISH;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_FETCH;
                  ramEn_d = 1'b1;
               end
            end
         end
         ST_FETCH: begin
            if (rdSlot_q == LAST_SLOT) begin
               state_d = ST_DRAIN;
            end else begin
               ramEn_d   = 1'b1;
               ramAddr_d = ptr_q;
               ptr_d     = ptr_q + ADDR_WIDTH'(1);
               rdSlot_d  = rdSlot_q + SLOT_WIDTH'(1);
            end
         end
         ST_DRAIN: begin
            if (capEn_q && (capSlot_q == LAST_SLOT)) begin
               recValid_d = 1'b1;
               state_d    = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (rec_ready) begin
               recValid_d = 1'b0;
               cnt_d      = cnt_q - CNT_WIDTH'(1);
               if (cnt_q == CNT_WIDTH'(1)) begin
                  state_d = ST_FINISH;
                  done_d  = 1'b1;
               end else begin
                  state_d   = ST_FETCH;
                  ramEn_d   = 1'b1;
                  ramAddr_d = ptr_q;
                  ptr_d     = ptr_q + ADDR_WIDTH'(1);
                  rdSlot_d  = '0;
               end
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort wins over everything decided above, including a transfer
      // happening on the same edge; outstanding captures are dropped.
      if (abort) begin
         state_d    = ST_IDLE;
         ramEn_d    = 1'b0;
         recValid_d = 1'b0;
         done_d     = 1'b0;
         capEn_d    = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         rdSlot_q   <= '0;
         capEn_q    <= 1'b0;
         capSlot_q  <= '0;
         ramEn_q    <= 1'b0;
         ramAddr_q  <= '0;
         recData_q  <= '0;
         recValid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         rdSlot_q   <= rdSlot_d;
         capEn_q    <= capEn_d;
         capSlot_q  <= capSlot_d;
         ramEn_q    <= ramEn_d;
         ramAddr_q  <= ramAddr_d;
         recData_q  <= recData_d;
         recValid_q <= recValid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign ram_enable  = ramEn_q;
   assign ram_address = ramAddr_q;
   assign rec_data    = recData_q;
   assign rec_valid   = recValid_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_ram_record_reader.sv
// Testbench for ram_record_reader: a synchronous-read RAM model feeds the
// reader, directed command vectors are applied from a table, and a few
// hand-written sequences cover stalls, ignored starts, abort and reset.
module tb_ram_record_reader;

   logic        clock;
   logic        reset;
   logic        start;
   logic [10:0] base_addr;
   logic [6:0]  rec_count;
   logic        abort;
   logic        ram_enable;
   logic [10:0] ram_address;
   logic [7:0]  ram_q;
   logic [31:0] rec_data;
   logic        rec_valid;
   logic        rec_ready;
   logic        busy;
   logic        done;

   ram_record_reader #(
      .ADDR_WIDTH(11),
      .DATA_WIDTH(8),
      .REC_BYTES(4),
      .CNT_WIDTH(7)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .base_addr(base_addr),
      .rec_count(rec_count),
      .abort(abort),
      .ram_enable(ram_enable),
      .ram_address(ram_address),
      .ram_q(ram_q),
      .rec_data(rec_data),
      .rec_valid(rec_valid),
      .rec_ready(rec_ready),
      .busy(busy),
      .done(done)
   );

   // Clock and free-running cycle counter.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Synchronous-read RAM: data appears one edge after the enabled address.
   logic [7:0] mem [0:2047];
   always @(posedge clock) begin
      if (ram_enable) ram_q <= mem[ram_address];
   end

   // Observers on the falling edge: transferred records, issued addresses,
   // done pulses and the cycles in which rec_valid rises.
   logic [31:0] recQ [$];
   logic [10:0] addrQ [$];
   int          riseQ [$];
   int          doneCnt = 0;
   logic        prevValid = 1'b0;

   always @(negedge clock) begin
      if (rec_valid && rec_ready) recQ.push_back(rec_data);
      if (ram_enable) addrQ.push_back(ram_address);
      if (done) doneCnt = doneCnt + 1;
      if (rec_valid && !prevValid) riseQ.push_back(cyc);
      prevValid = rec_valid;
   end

   int passChecks = 0;
   int totalChecks = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalChecks++;
      if (act === exp) passChecks++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Pulse start for one edge; returns the cycle number of the start edge.
   // Entered and left just after a rising edge.
   task automatic startCmd(input logic [10:0] b, input logic [6:0] n, output int e0);
      start = 1'b1;
      base_addr = b;
      rec_count = n;
      @(posedge clock); #1;
      start = 1'b0;
      e0 = cyc;
   endtask

   // Wait (bounded) for done; doneAt stays -1 if it never comes.
   task automatic waitDone(input int maxCyc, output int doneAt, output int busyLow);
      doneAt = -1;
      busyLow = 0;
      for (int i = 0; i < maxCyc; i++) begin
         if (!busy) busyLow++;
         if (done) begin
            doneAt = cyc;
            break;
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic applyStimulus(input logic [10:0] b, input logic [6:0] n, input int maxCyc,
                                output int e0, output int doneAt, output int busyLow);
      startCmd(b, n, e0);
      waitDone(maxCyc, doneAt, busyLow);
   endtask

   // Cancel record 1 of a 3-record command during its fetch, either by abort
   // or by reset, then confirm a fresh command still reads correctly.
   task automatic cancelSequence(input bit useReset, input string tag);
      int e0, doneAt, busyLow, recBase, doneBase, addrBase;
      recBase = recQ.size();
      doneBase = doneCnt;
      startCmd(11'h200, 7'd3, e0);
      for (int i = 0; i < 20 && cyc < e0 + 7; i++) begin
         @(posedge clock); #1;
      end
      if (useReset) reset = 1'b1;
      else abort = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      abort = 1'b0;
      checkOutput({tag, " rec_valid"}, 32'(rec_valid), 32'd0);
      checkOutput({tag, " busy"}, 32'(busy), 32'd0);
      checkOutput({tag, " done"}, 32'(done), 32'd0);
      checkOutput({tag, " ram_enable"}, 32'(ram_enable), 32'd0);
      checkOutput({tag, " records before cancel"}, recQ.size() - recBase, 32'd1);
      if (recQ.size() > recBase) checkOutput({tag, " record 0"}, recQ[recBase], 32'h13121110);
      repeat (8) begin
         @(posedge clock); #1;
      end
      checkOutput({tag, " no done"}, doneCnt - doneBase, 32'd0);
      recBase = recQ.size();
      addrBase = addrQ.size();
      applyStimulus(11'h100, 7'd1, 30, e0, doneAt, busyLow);
      checkOutput({tag, " restart done offset"}, doneAt - e0, 32'd6);
      checkOutput({tag, " restart record count"}, recQ.size() - recBase, 32'd1);
      if (recQ.size() > recBase) checkOutput({tag, " restart record"}, recQ[recBase], 32'h04030201);
      if (addrQ.size() > addrBase) checkOutput({tag, " restart first addr"}, 32'(addrQ[addrBase]), 32'h100);
      @(posedge clock); #1;
   endtask

   typedef struct packed {
      logic [10:0] base;
      logic [6:0]  count;
      logic [31:0] exp0;
      logic [31:0] exp1;
      logic [31:0] exp2;
      int          doneOfs;
   } vec_t;

   vec_t vecs [4];

   int e0, doneAt, busyLow, recBase, addrBase, riseBase, doneBase, stallBad;
   logic [31:0] expRec;
   logic [10:0] expA;

   // Main test sequence.
   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'hEE;
      for (int i = 0; i < 8; i++) mem[11'h100 + i] = 8'(i + 1);
      for (int i = 0; i < 12; i++) mem[11'h200 + i] = 8'(8'h10 + i);
      mem[11'h7FE] = 8'hA1;
      mem[11'h7FF] = 8'hA2;
      mem[11'h000] = 8'hA3;
      mem[11'h001] = 8'hA4;

      vecs[0] = '{base: 11'h100, count: 7'd2, exp0: 32'h04030201, exp1: 32'h08070605, exp2: 32'h0, doneOfs: 12};
      vecs[1] = '{base: 11'h7FE, count: 7'd1, exp0: 32'hA4A3A2A1, exp1: 32'h0, exp2: 32'h0, doneOfs: 6};
      vecs[2] = '{base: 11'h200, count: 7'd3, exp0: 32'h13121110, exp1: 32'h17161514, exp2: 32'h1B1A1918, doneOfs: 18};
      vecs[3] = '{base: 11'h105, count: 7'd0, exp0: 32'h0, exp1: 32'h0, exp2: 32'h0, doneOfs: 0};

      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      base_addr = '0;
      rec_count = '0;
      rec_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset ram_enable", 32'(ram_enable), 32'd0);
      checkOutput("reset ram_address", 32'(ram_address), 32'd0);
      checkOutput("reset rec_data", rec_data, 32'd0);
      checkOutput("reset rec_valid", 32'(rec_valid), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      // Table-driven commands with rec_ready held high.
      for (int v = 0; v < 4; v++) begin
         recBase = recQ.size();
         addrBase = addrQ.size();
         riseBase = riseQ.size();
         doneBase = doneCnt;
         applyStimulus(vecs[v].base, vecs[v].count, 40, e0, doneAt, busyLow);
         checkOutput($sformatf("v%0d done offset", v), doneAt - e0, vecs[v].doneOfs);
         checkOutput($sformatf("v%0d busy low", v), busyLow, 32'd0);
         @(posedge clock); #1;
         checkOutput($sformatf("v%0d busy after", v), 32'(busy), 32'd0);
         checkOutput($sformatf("v%0d done after", v), 32'(done), 32'd0);
         checkOutput($sformatf("v%0d done count", v), doneCnt - doneBase, 32'd1);
         checkOutput($sformatf("v%0d record count", v), recQ.size() - recBase, 32'(vecs[v].count));
         checkOutput($sformatf("v%0d address count", v), addrQ.size() - addrBase, 4 * int'(vecs[v].count));
         for (int r = 0; r < int'(vecs[v].count); r++) begin
            expRec = (r == 0) ? vecs[v].exp0 : (r == 1) ? vecs[v].exp1 : vecs[v].exp2;
            if (recBase + r < recQ.size())
               checkOutput($sformatf("v%0d record %0d", v, r), recQ[recBase + r], expRec);
         end
         for (int k = 0; k < 4 * int'(vecs[v].count); k++) begin
            expA = vecs[v].base + 11'(k);
            if (addrBase + k < addrQ.size())
               checkOutput($sformatf("v%0d address %0d", v, k), 32'(addrQ[addrBase + k]), 32'(expA));
         end
         if (vecs[v].count != 0 && riseQ.size() > riseBase)
            checkOutput($sformatf("v%0d first valid offset", v), riseQ[riseBase] - e0, 32'd5);
      end

      // Back-pressure: hold rec_ready low for 10 cycles on the first record.
      rec_ready = 1'b0;
      recBase = recQ.size();
      doneBase = doneCnt;
      startCmd(11'h100, 7'd2, e0);
      for (int i = 0; i < 20 && !rec_valid; i++) begin
         @(posedge clock); #1;
      end
      checkOutput("bp valid offset", cyc - e0, 32'd5);
      stallBad = 0;
      for (int i = 0; i < 10; i++) begin
         if (!rec_valid || rec_data !== 32'h04030201 || ram_enable) stallBad++;
         @(posedge clock); #1;
      end
      checkOutput("bp stall violations", stallBad, 32'd0);
      checkOutput("bp held data", rec_data, 32'h04030201);
      rec_ready = 1'b1;
      @(posedge clock); #1;
      checkOutput("bp next read enable", 32'(ram_enable), 32'd1);
      checkOutput("bp next read addr", 32'(ram_address), 32'h104);
      checkOutput("bp valid cleared", 32'(rec_valid), 32'd0);
      waitDone(30, doneAt, busyLow);
      checkOutput("bp busy low", busyLow, 32'd0);
      checkOutput("bp record count", recQ.size() - recBase, 32'd2);
      if (recQ.size() > recBase + 1) checkOutput("bp record 1", recQ[recBase + 1], 32'h08070605);
      @(posedge clock); #1;
      checkOutput("bp done count", doneCnt - doneBase, 32'd1);

      // Start pulsed mid-command must be ignored.
      recBase = recQ.size();
      addrBase = addrQ.size();
      doneBase = doneCnt;
      startCmd(11'h200, 7'd3, e0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      start = 1'b1;
      base_addr = 11'h100;
      rec_count = 7'd1;
      @(posedge clock); #1;
      start = 1'b0;
      waitDone(60, doneAt, busyLow);
      checkOutput("sb done offset", doneAt - e0, 32'd18);
      checkOutput("sb record count", recQ.size() - recBase, 32'd3);
      if (recQ.size() > recBase + 2) begin
         checkOutput("sb record 0", recQ[recBase], 32'h13121110);
         checkOutput("sb record 2", recQ[recBase + 2], 32'h1B1A1918);
      end
      checkOutput("sb address count", addrQ.size() - addrBase, 32'd12);
      if (addrQ.size() > addrBase + 11) checkOutput("sb last address", 32'(addrQ[addrBase + 11]), 32'h20B);
      @(posedge clock); #1;
      checkOutput("sb done count", doneCnt - doneBase, 32'd1);

      cancelSequence(1'b0, "abort");
      cancelSequence(1'b1, "reset");

      $display("%0d/%0d checks passed", passChecks, totalChecks);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog");
   end

endmodule

// File: doc/ram_record_reader.md
# ram_record_reader

Sequential reader for the synchronous-read port of the design's dual-port block RAMs (sprite/object and colour RAM). On a start command it walks a contiguous address range, gathers REC_BYTES consecutive bytes per record and presents each record on a valid/ready stream. Video-side consumers use it in place of raw port-B address sequencing. The CPU side keeps port A.

## Interface
- ADDR_WIDTH, 11: RAM address width.
- DATA_WIDTH, 8: RAM word width.
- REC_BYTES, 4: words per record (1..8).
- CNT_WIDTH, 7: width of the record-count input.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first RAM address, latched on accepted start.
- rec_count  in  CNT_WIDTH  number of records, latched on accepted start.
- abort  in  1  cancel the current command.
- ram_enable  out  1  RAM port enable; read-only port, write enable is tied low externally.
- ram_address  out  ADDR_WIDTH  RAM port address.
- ram_q  in  DATA_WIDTH  RAM read data, registered by the RAM one edge after enable.
- rec_data  out  REC_BYTES*DATA_WIDTH  assembled record; word k sits at bits [k*DATA_WIDTH +: DATA_WIDTH].
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts record.
- busy  out  1  high in any state but IDLE.
- done  out  1  one-cycle pulse when a command completes normally.

## Operation
- States are IDLE, FETCH, DRAIN, HOLD and FINISH.
- **IDLE:** on start=1, latch base_addr into the address pointer and rec_count into the remaining counter.
  - If rec_count=0, go to FINISH.
  - Otherwise go to FETCH.
- **FETCH:** assert ram_enable for exactly REC_BYTES consecutive cycles.
  - ram_address increments by 1 each cycle.
  - Address arithmetic is modulo 2^ADDR_WIDTH, so 0x7FF is followed by 0x000.
  - After the last issue, go to DRAIN. ram_enable drops to 0.
- **DRAIN:** wait for the final read data. Capture runs in FETCH and DRAIN.
  - Each ram_q word is captured two edges after its address was driven: one edge for the RAM, one for the capture register.
  - Word k goes to slot k.
  - When slot REC_BYTES-1 is captured, set rec_valid and go to HOLD.
- **HOLD:** rec_valid=1. rec_data is stable until transfer.
  - Transfer happens on an edge where rec_valid and rec_ready are both 1. On transfer, clear rec_valid and decrement the counter.
  - If the counter becomes 0, go to FINISH; otherwise go to FETCH.
  - The pointer continues from the word after the previous record.
- **FINISH:** done=1 for one cycle, then IDLE.
- start is ignored in any state but IDLE.
- abort=1 in any state returns to IDLE on that edge:
  - rec_valid, ram_enable and busy go to 0;
  - no done pulse;
  - a partially captured record is discarded.
- abort has priority over start and over the rec_ready transfer.
- Records are not overlapped: the next record's reads begin only after the handshake.

## Timing
- Reset values: state IDLE; ram_enable=0, ram_address=0, rec_data=0, rec_valid=0, busy=0, done=0, pointer=0, counter=0.
- All outputs are registered.
- Let the start edge be E0. Reads are driven after edges E0..E(REC_BYTES-1).
- rec_valid goes high after edge E(REC_BYTES+1). With REC_BYTES=4 that is 5 edges after start.
- From a handshake at Ex, the next record's first address is driven after Ex and its rec_valid goes high after Ex+REC_BYTES+1.
- Sustained period with rec_ready tied high: REC_BYTES+2 cycles per record.
- done is high during the cycle after the final handshake edge. busy falls on the same edge that done falls.
- With rec_count=0, done pulses in the cycle after the start edge and ram_enable never asserts.
- reset has priority over abort and over start.

## Test plan
- **Basic read:** RAM[0x100..0x107] = 01..08; start with base 0x100, count 2, rec_ready=1.
  - Record 0 must be 0x04030201 and record 1 must be 0x08070605.
  - rec_valid must first rise 5 edges after start.
  - done pulses once; busy is high throughout.
- **Back-pressure:** same setup, rec_ready=0 for 10 cycles.
  - rec_valid stays 1 and rec_data stays 0x04030201, with no ram_enable during the stall.
  - The second record's reads begin the cycle after the handshake.
- **Wrap-around:** base 0x7FE, count 1.
  - Read addresses must be 0x7FE, 0x7FF, 0x000, 0x001, and rec_data must reflect those words.
- **Zero count, and start while busy:**
  - count=0 gives done exactly one cycle after start, with no RAM access.
  - A second start pulsed mid-command must not change the pointer, the counter or the output sequence.
- **Abort and reset mid-operation:**
  - Abort during FETCH of record 1 of 3 gives rec_valid=0, busy=0 and no done on the next edge.
  - A fresh start then reads correctly from its new base.
  - Repeat the same stimulus using reset instead of abort: the required response is identical.
